queue_min_reader: RTL and testbench

- Read-side companion to the queue slot array: on request, scans all queue slots through a one-slot-per-cycle read port.
- Selects the occupied slot with the lowest frequency and returns its ascii, frequency, head flag and queue position.
- Issues a one-cycle clear to the selected slot so that slot is removed from the queue.
- The tree-build controller calls it twice per merge step to obtain the two lowest-frequency nodes.

---
 rtl/queue_min_reader_if.sv | 65 ++++++
 rtl/queue_min_reader.sv | 176 +++++++++++++++++
 tb/tb_queue_min_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/queue_min_reader_if.sv
// rtl/queue_min_reader_if.sv - request, slot read/clear and result bundle of the extract-min reader
interface queue_min_reader_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             busy;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       rd_ascii;
  logic [31:0]      rd_freq;
  logic             rd_head;
  logic [7:0]       rd_queue_pos;
  logic             clr_en;
  logic [IDX_W-1:0] clr_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_empty;
  logic [7:0]       out_ascii;
  logic [31:0]      out_freq;
  logic             out_head;
  logic [7:0]       out_queue_pos;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;

  modport master (
    input  start,
    output busy,
    output rd_idx,
    input  rd_ascii,
    input  rd_freq,
    input  rd_head,
    input  rd_queue_pos,
    output clr_en,
    output clr_idx,
    output out_valid,
    input  out_ready,
    output out_empty,
    output out_ascii,
    output out_freq,
    output out_head,
    output out_queue_pos,
    output out_idx,
    output out_count
  );

  modport slave (
    output start,
    input  busy,
    input  rd_idx,
    output rd_ascii,
    output rd_freq,
    output rd_head,
    output rd_queue_pos,
    input  clr_en,
    input  clr_idx,
    input  out_valid,
    output out_ready,
    input  out_empty,
    input  out_ascii,
    input  out_freq,
    input  out_head,
    input  out_queue_pos,
    input  out_idx,
    input  out_count
  );
endinterface

// File: rtl/queue_min_reader.sv
// rtl/queue_min_reader.sv - scans all queue slots, returns and clears the lowest-frequency occupied slot
module queue_min_reader #(
  parameter int NUM_SLOTS = 256,
  parameter int IDX_W     = 8
) (
  input  logic               clk,
  input  logic               ctrl_reset,
  queue_min_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  state_t           state;
  state_t           nextState;
  logic [IDX_W-1:0] scanIdx;
  logic             found;
  logic [7:0]       bestAscii;
  logic [31:0]      bestFreq;
  logic             bestHead;
  logic [7:0]       bestPos;
  logic [IDX_W-1:0] bestIdx;
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] clrIdxHold;

  logic             outEmpty;
  logic [7:0]       outAscii;
  logic [31:0]      outFreq;
  logic             outHead;
  logic [7:0]       outPos;
  logic [IDX_W-1:0] outIdx;
  logic [IDX_W:0]   outCount;

  logic slotOccupied;
  logic takeSlot;

  // Strict compare keeps the earliest (lowest-index) slot on a frequency tie.
  assign slotOccupied = (bus.rd_freq != 32'd0);
  assign takeSlot     = slotOccupied && (!found || (bus.rd_freq < bestFreq));

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState   = state;
    bus.busy    = 1'b0;
    bus.rd_idx  = '0;
    bus.clr_en  = 1'b0;
    bus.clr_idx = clrIdxHold;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nextState = SCAN;
        end
      end
      SCAN: begin
        bus.busy   = 1'b1;
        bus.rd_idx = scanIdx;
        if (scanIdx == LAST_IDX) begin
          nextState = CLEAR;
        end
      end
      CLEAR: begin
        bus.busy   = 1'b1;
        bus.clr_en = found;
        if (found) begin
          bus.clr_idx = bestIdx;
        end
        nextState = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ctrl_reset) begin
      scanIdx    <= '0;
      found      <= 1'b0;
      bestAscii  <= '0;
      bestFreq   <= '0;
      bestHead   <= 1'b0;
      bestPos    <= '0;
      bestIdx    <= '0;
      count      <= '0;
      clrIdxHold <= '0;
      outEmpty   <= 1'b0;
      outAscii   <= '0;
      outFreq    <= '0;
      outHead    <= 1'b0;
      outPos     <= '0;
      outIdx     <= '0;
      outCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            scanIdx   <= '0;
            found     <= 1'b0;
            bestAscii <= '0;
            bestFreq  <= '0;
            bestHead  <= 1'b0;
            bestPos   <= '0;
            bestIdx   <= '0;
            count     <= '0;
            outEmpty  <= 1'b0;
            outAscii  <= '0;
            outFreq   <= '0;
            outHead   <= 1'b0;
            outPos    <= '0;
            outIdx    <= '0;
            outCount  <= '0;
          end
        end
        SCAN: begin
          scanIdx <= scanIdx + 1'b1;
          if (slotOccupied) begin
            count <= count + 1'b1;
          end
          if (takeSlot) begin
            found     <= 1'b1;
            bestAscii <= bus.rd_ascii;
            bestFreq  <= bus.rd_freq;
            bestHead  <= bus.rd_head;
            bestPos   <= bus.rd_queue_pos;
            bestIdx   <= scanIdx;
          end
        end
        CLEAR: begin
          if (found) begin
            clrIdxHold <= bestIdx;
          end
          // Best registers are still zero when nothing was found, giving all-zero fields.
          outEmpty <= !found;
          outAscii <= bestAscii;
          outFreq  <= bestFreq;
          outHead  <= bestHead;
          outPos   <= bestPos;
          outIdx   <= bestIdx;
          outCount <= count;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_empty     = outEmpty;
  assign bus.out_ascii     = outAscii;
  assign bus.out_freq      = outFreq;
  assign bus.out_head      = outHead;
  assign bus.out_queue_pos = outPos;
  assign bus.out_idx       = outIdx;
  assign bus.out_count     = outCount;

endmodule

// File: tb/tb_queue_min_reader.sv
// tb/tb_queue_min_reader.sv - randomized scoreboard bench for queue_min_reader
module tb_queue_min_reader;
  localparam int NUM_SLOTS = 4;
  localparam int IDX_W     = 2;

  logic clk = 1'b0;
  logic ctrl_reset;
  always #5 clk = ~clk;

  queue_min_reader_if #(.IDX_W(IDX_W)) bus ();

  queue_min_reader #(.NUM_SLOTS(NUM_SLOTS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  logic [7:0]  slotAscii [NUM_SLOTS];
  logic [31:0] slotFreq  [NUM_SLOTS];
  logic        slotHead  [NUM_SLOTS];
  logic [7:0]  slotPos   [NUM_SLOTS];

  assign bus.rd_ascii     = slotAscii[bus.rd_idx];
  assign bus.rd_freq      = slotFreq[bus.rd_idx];
  assign bus.rd_head      = slotHead[bus.rd_idx];
  assign bus.rd_queue_pos = slotPos[bus.rd_idx];

  typedef struct {
    logic             empty;
    logic [7:0]       ascii;
    logic [31:0]      freq;
    logic             head;
    logic [7:0]       pos;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   count;
  } result_t;

  result_t          sbQ[$];
  logic [IDX_W-1:0] clrQ[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: minimum nonzero frequency over the array, first occurrence wins.
  function automatic result_t model();
    result_t r;
    int best;
    best = -1;
    r = '{default: 0};
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slotFreq[i] != 0) begin
        r.count = r.count + 1'b1;
        if (best < 0 || slotFreq[i] < slotFreq[best]) best = i;
      end
    end
    if (best < 0) begin
      r.empty = 1'b1;
    end else begin
      r.ascii = slotAscii[best];
      r.freq  = slotFreq[best];
      r.head  = slotHead[best];
      r.pos   = slotPos[best];
      r.idx   = IDX_W'(best);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.clr_en) begin
      if (clrQ.size() == 0) begin
        checks++;
        $display("FAIL unexpected_clr: got clr_en=1 clr_idx=%0d expected no clear", bus.clr_idx);
      end else begin
        chk("clr_idx", bus.clr_idx, clrQ.pop_front());
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (sbQ.size() == 0) begin
        $display("FAIL unexpected_result: got out_valid=1 expected no result");
      end else begin
        result_t e;
        e = sbQ.pop_front();
        if (bus.out_empty === e.empty && bus.out_ascii === e.ascii && bus.out_freq === e.freq &&
            bus.out_head === e.head && bus.out_queue_pos === e.pos && bus.out_idx === e.idx &&
            bus.out_count === e.count)
          passes++;
        else
          $display("FAIL result: got empty=%0d ascii=%0h freq=%0h head=%0d pos=%0h idx=%0d count=%0d expected empty=%0d ascii=%0h freq=%0h head=%0d pos=%0h idx=%0d count=%0d",
                   bus.out_empty, bus.out_ascii, bus.out_freq, bus.out_head, bus.out_queue_pos,
                   bus.out_idx, bus.out_count, e.empty, e.ascii, e.freq, e.head, e.pos, e.idx, e.count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outSnap();
    return 64'({bus.out_empty, bus.out_ascii, bus.out_freq, bus.out_head,
                bus.out_queue_pos, bus.out_idx, bus.out_count});
  endfunction

  task automatic runOp(input int stall, input bit startAtHandshake);
    result_t exp;
    int lat;
    int clrs;
    logic [63:0] snap;
    exp = model();
    sbQ.push_back(exp);
    if (!exp.empty) clrQ.push_back(exp.idx);
    clrs = 0;
    lat = 0;
    bus.out_ready = (stall == 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
      if (bus.clr_en) begin
        clrs++;
        slotFreq[bus.clr_idx] = 32'd0;
      end
    end
    if (lat >= 50) begin
      checks++;
      $display("FAIL timeout: got no out_valid after %0d cycles expected %0d", lat, NUM_SLOTS + 1);
      ctrl_reset = 1'b1;
      tick();
      ctrl_reset = 1'b0;
      sbQ.delete();
      clrQ.delete();
      bus.out_ready = 1'b0;
      return;
    end
    chk("latency", lat, NUM_SLOTS + 1);
    chk("clr_pulses", clrs, exp.empty ? 0 : 1);
    if (stall > 0) begin
      snap = outSnap();
      for (int i = 0; i < stall; i++) begin
        bus.start = (i == stall / 2);
        tick();
        bus.start = 1'b0;
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_stable", outSnap(), snap);
      end
      bus.out_ready = 1'b1;
    end
    bus.start = startAtHandshake;
    tick();
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    chk("busy_after_hs", bus.busy, 0);
    chk("valid_after_hs", bus.out_valid, 0);
    chk("fields_held", {bus.out_idx, bus.out_freq}, {exp.idx, exp.freq});
    tick();
    chk("idle_stays", bus.busy, 0);
    chk("rd_idx_idle", bus.rd_idx, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    ctrl_reset = 1'b1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotAscii[i] = 8'h0; slotFreq[i] = 32'h0; slotHead[i] = 1'b0; slotPos[i] = 8'h0;
    end
    repeat (3) tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_clr", {bus.clr_en, bus.clr_idx}, 0);
    chk("reset_fields", outSnap(), 0);
    ctrl_reset = 1'b0;
    tick();

    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotAscii[i] = 8'h41 + 8'(i);
      slotHead[i]  = i[0];
      slotPos[i]   = 8'd10 + 8'(i);
    end
    slotFreq[0] = 5; slotFreq[1] = 3; slotFreq[2] = 9; slotFreq[3] = 3;
    runOp(0, 0);
    chk("slot1_cleared", slotFreq[1], 0);
    runOp(0, 0);

    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotFreq[i] = 0; slotHead[i] = 1'b1; slotAscii[i] = 8'h5A;
    end
    runOp(0, 0);

    for (int i = 0; i < NUM_SLOTS; i++) slotFreq[i] = $urandom_range(1, 20);
    runOp(10, 1);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    ctrl_reset = 1'b1;
    tick();
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_ctl", {bus.out_valid, bus.clr_en, bus.clr_idx, bus.rd_idx}, 0);
    chk("rst_mid_fields", outSnap(), 0);
    ctrl_reset = 1'b0;
    repeat (8) tick();
    runOp(0, 0);

    for (int i = 0; i < NUM_SLOTS; i++) slotFreq[i] = 0;
    slotFreq[NUM_SLOTS-1] = 32'hFFFF_FFFF;
    slotHead[NUM_SLOTS-1] = 1'b1;
    slotPos[NUM_SLOTS-1]  = 8'h7F;
    runOp(0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          case ($urandom_range(0, 3))
            0: slotFreq[i] = 0;
            1: slotFreq[i] = $urandom_range(1, 4);
            2: slotFreq[i] = 32'hFFFF_FFFF;
            default: slotFreq[i] = $urandom;
          endcase
          slotAscii[i] = 8'($urandom);
          slotHead[i]  = 1'($urandom);
          slotPos[i]   = 8'($urandom);
        end
      end
      runOp($urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (4) tick();
    chk("scoreboard_drained", sbQ.size() + clrQ.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
